first_phase_m_stream: RTL and testbench
=======================================

// Module: first_phase_m_stream
//
// PURPOSE
// Parametrised successor of the multiplier first-phase operand capture stage.
// Captures operand pairs (X, Y) into a DEPTH-entry FIFO with valid/ready handshakes
// on both sides, so the multiplier datapath can stall without dropping operands.
// Each entry carries precomputed IEEE-754 special-case flags (zero/inf/NaN) and the
// result sign, so the next phase needs no extra decode cycle. Sits between the FPU
// input interface and the multiplier's exponent/significand phases.
//
// PARAMETERS
// W      32  operand width (32 single, 64 double)
// EW      8  exponent field width (8 single, 11 double); mantissa width MW = W-1-EW
// DEPTH   2  FIFO entries; power of two, >= 2
// CW      2  count width = clog2(DEPTH)+1
//
// PORTS
// clk       in   1      system clock, all state on rising edge
// rst       in   1      synchronous reset, active-low (0 = reset)
// flush     in   1      synchronous clear of all queued entries
// in_valid  in   1      Data_MX/Data_MY valid
// in_ready  out  1      stage can accept a pair this cycle
// Data_MX   in   W      operand X
// Data_MY   in   W      operand Y
// out_valid out  1      head entry valid
// out_ready in   1      downstream accepts head entry
// Op_MX     out  W      head operand X
// Op_MY     out  W      head operand Y
// sign_r    out  1      Op_MX[W-1] ^ Op_MY[W-1]
// zero_x    out  1      X exponent field == 0 (denormals flushed to zero)
// zero_y    out  1      same for Y
// inf_x     out  1      X exponent all ones, mantissa == 0
// inf_y     out  1      same for Y
// nan_x     out  1      X exponent all ones, mantissa != 0
// nan_y     out  1      same for Y
// count     out  CW     entries currently held (0..DEPTH)
//
// BEHAVIOUR
// - Reset (rst==0 at clock edge): count=0, pointers=0, out_valid=0; in_ready=1 from
//   the first cycle after rst returns high. Reset wins over flush, push and pop.
// - push = in_valid & in_ready; pop = out_valid & out_ready.
// - in_ready = (count != DEPTH); depends only on state, never on out_ready.
//   Full FIFO therefore rejects a push even if a pop occurs in the same cycle.
// - out_valid = (count != 0); first-word-fall-through: head entry on outputs.
// - Latency: pair accepted at edge N -> out_valid=1 and data visible after edge N.
// - Push only: write at wr_ptr, wr_ptr+1, count+1. Pop only: rd_ptr+1, count-1.
//   Push and pop together: both pointers advance, count unchanged (also valid at
//   count==1: new entry becomes head after the edge).
// - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
// - Flags and sign_r computed from Data_MX/Data_MY at push and stored with the entry.
// - When out_valid==0, Op_MX, Op_MY, sign_r and all flags are driven to 0.
// - flush==1: count=0, pointers=0 at the edge; a push in the same cycle is dropped;
//   out_valid=0 next cycle. in_ready unaffected by flush itself.
// - Held data is stable while out_valid & ~out_ready (no change until popped).
//
// TESTING
// 1 Reset: hold rst=0 with in_valid=1 -> count=0, out_valid=0, outputs 0; in_ready=1
//   after release.
// 2 Push X=32'h3F800000, Y=32'hC0000000 -> next cycle out_valid=1, Op_MX/Op_MY match,
//   sign_r=1, all zero/inf/nan flags 0.
// 3 Backpressure: out_ready=0, push 3 pairs (DEPTH=2) -> first two stored, in_ready=0,
//   third held by source; release out_ready -> pairs emerge in order, none lost.
// 4 Special cases: X=32'h7F800000, Y=32'h7FC00001 -> inf_x=1, nan_y=1; X=32'h00000001
//   -> zero_x=1.
// 5 Simultaneous push/pop at count=1 for 8 cycles -> count stays 1, data in order,
//   pointers wrap cleanly.
// 6 flush with count=2 and in_valid=1 -> count=0, out_valid=0 next cycle, pushed pair
//   discarded.

Source files
------------

// File: rtl/first_phase_m_stream.sv
// Operand capture stage for the multiplier first phase: a DEPTH-entry FWFT FIFO of
// (X, Y) pairs, each stored with its precomputed IEEE-754 special-case flags and result sign.
module first_phase_m_stream #(
  parameter int W     = 32,
  parameter int EW    = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  Data_MX,
  input  logic [W-1:0]  Data_MY,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  Op_MX,
  output logic [W-1:0]  Op_MY,
  output logic          sign_r,
  output logic          zero_x,
  output logic          zero_y,
  output logic          inf_x,
  output logic          inf_y,
  output logic          nan_x,
  output logic          nan_y,
  output logic [CW-1:0] count
);

  localparam int MW = W - 1 - EW;
  localparam int PW = $clog2(DEPTH);

  // Stored flag vector order: {sign, zero_x, zero_y, inf_x, inf_y, nan_x, nan_y}
  localparam int FW = 7;

  logic [W-1:0]  r_mx    [DEPTH];
  logic [W-1:0]  r_my    [DEPTH];
  logic [FW-1:0] r_flags [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  logic          w_in_ready;
  logic          w_out_valid;

  logic [EW-1:0] w_exp_x;
  logic [EW-1:0] w_exp_y;
  logic [MW-1:0] w_man_x;
  logic [MW-1:0] w_man_y;
  logic          w_exp_x_ones;
  logic          w_exp_y_ones;
  logic [FW-1:0] w_flags_in;
  logic [FW-1:0] w_flags_head;

  assign w_in_ready  = (r_count != CW'(DEPTH));
  assign w_out_valid = (r_count != '0);
  assign w_push      = in_valid & w_in_ready;
  assign w_pop       = w_out_valid & out_ready;

  assign w_exp_x      = Data_MX[W-2 -: EW];
  assign w_exp_y      = Data_MY[W-2 -: EW];
  assign w_man_x      = Data_MX[MW-1:0];
  assign w_man_y      = Data_MY[MW-1:0];
  assign w_exp_x_ones = &w_exp_x;
  assign w_exp_y_ones = &w_exp_y;

  // Denormals have a zero exponent field and are treated as zero.
  assign w_flags_in = {
    Data_MX[W-1] ^ Data_MY[W-1],
    (w_exp_x == '0),
    (w_exp_y == '0),
    w_exp_x_ones & (w_man_x == '0),
    w_exp_y_ones & (w_man_y == '0),
    w_exp_x_ones & (w_man_x != '0),
    w_exp_y_ones & (w_man_y != '0)
  };

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (rst && !flush && w_push) begin
      r_mx[r_wr_ptr]    <= Data_MX;
      r_my[r_wr_ptr]    <= Data_MY;
      r_flags[r_wr_ptr] <= w_flags_in;
    end
  end

  assign w_flags_head = w_out_valid ? r_flags[r_rd_ptr] : '0;

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign count     = r_count;
  assign Op_MX     = w_out_valid ? r_mx[r_rd_ptr] : '0;
  assign Op_MY     = w_out_valid ? r_my[r_rd_ptr] : '0;
  assign sign_r    = w_flags_head[6];
  assign zero_x    = w_flags_head[5];
  assign zero_y    = w_flags_head[4];
  assign inf_x     = w_flags_head[3];
  assign inf_y     = w_flags_head[2];
  assign nan_x     = w_flags_head[1];
  assign nan_y     = w_flags_head[0];

endmodule

// File: tb/tb_first_phase_m_stream.sv
// Directed bench for first_phase_m_stream (W=32, DEPTH=2): handshake, ordering,
// special-case flags, wrap-around and flush.
module tb_first_phase_m_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Data_MX;
  logic [31:0] Data_MY;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Op_MX;
  logic [31:0] Op_MY;
  logic        sign_r;
  logic        zero_x, zero_y, inf_x, inf_y, nan_x, nan_y;
  logic [1:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  first_phase_m_stream #(.W(32), .EW(8), .DEPTH(2), .CW(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .Data_MX(Data_MX), .Data_MY(Data_MY),
    .out_valid(out_valid), .out_ready(out_ready),
    .Op_MX(Op_MX), .Op_MY(Op_MY), .sign_r(sign_r),
    .zero_x(zero_x), .zero_y(zero_y), .inf_x(inf_x), .inf_y(inf_y),
    .nan_x(nan_x), .nan_y(nan_y), .count(count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] flags();
    return {zero_x, zero_y, inf_x, inf_y, nan_x, nan_y};
  endfunction

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    Data_MX = 32'h3F80_0000; Data_MY = 32'h4000_0000;

    // 1: reset holds the FIFO empty even with in_valid asserted
    repeat (3) step();
    check("rst_count", count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_op_mx", Op_MX, 0);
    check("rst_flags", {sign_r, flags()}, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    check("rst_in_ready", in_ready, 1);
    check("rst_count_after", count, 0);

    // 2: basic push, one-cycle latency
    in_valid = 1'b1; Data_MX = 32'h3F80_0000; Data_MY = 32'hC000_0000;
    step();
    in_valid = 1'b0;
    check("push_out_valid", out_valid, 1);
    check("push_op_mx", Op_MX, 32'h3F80_0000);
    check("push_op_my", Op_MY, 32'hC000_0000);
    check("push_sign", sign_r, 1);
    check("push_flags", flags(), 0);
    check("push_count", count, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("pop_count", count, 0);
    check("pop_out_valid", out_valid, 0);

    // 3: backpressure with three offered pairs
    in_valid = 1'b1; Data_MX = 32'h0000_00A1; Data_MY = 32'h0000_00B1;
    step();
    Data_MX = 32'h0000_00A2; Data_MY = 32'h0000_00B2;
    step();
    check("bp_full_count", count, 2);
    check("bp_in_ready", in_ready, 0);
    Data_MX = 32'h0000_00A3; Data_MY = 32'h0000_00B3;
    step();
    check("bp_held_count", count, 2);
    check("bp_head1", Op_MX, 32'h0000_00A1);
    out_ready = 1'b1;
    step();
    check("bp_drain1_count", count, 1);
    check("bp_head2_x", Op_MX, 32'h0000_00A2);
    check("bp_head2_y", Op_MY, 32'h0000_00B2);
    step();
    in_valid = 1'b0;
    check("bp_drain2_count", count, 1);
    check("bp_head3_x", Op_MX, 32'h0000_00A3);
    check("bp_head3_y", Op_MY, 32'h0000_00B3);
    step();
    out_ready = 1'b0;
    check("bp_empty", count, 0);

    // 4: special-case flags
    in_valid = 1'b1; Data_MX = 32'h7F80_0000; Data_MY = 32'h7FC0_0001;
    step();
    check("sp_inf_nan_flags", flags(), 6'b00_10_01);
    check("sp_inf_nan_sign", sign_r, 0);
    out_ready = 1'b1; Data_MX = 32'h0000_0001; Data_MY = 32'hBF80_0000;
    step();
    check("sp_swap_count", count, 1);
    check("sp_denorm_flags", flags(), 6'b10_00_00);
    check("sp_denorm_sign", sign_r, 1);
    Data_MX = 32'h8000_0000; Data_MY = 32'hFF80_0001;
    step();
    check("sp_neg_flags", flags(), 6'b10_00_01);
    check("sp_neg_sign", sign_r, 0);
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("sp_empty", count, 0);

    // 5: simultaneous push/pop at count==1 across pointer wrap
    in_valid = 1'b1; Data_MX = 32'h1000_0000; Data_MY = 32'h2000_0000;
    step();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      Data_MX = 32'h1000_0000 + 32'(i);
      Data_MY = 32'h2000_0000 + 32'(i);
      step();
      check($sformatf("pp_count_%0d", i), count, 1);
      check($sformatf("pp_x_%0d", i), Op_MX, 32'h1000_0000 + 32'(i));
      check($sformatf("pp_y_%0d", i), Op_MY, 32'h2000_0000 + 32'(i));
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("pp_empty", count, 0);

    // 6: flush when full and with an accepted push in the same cycle
    in_valid = 1'b1; Data_MX = 32'h0000_00E0; Data_MY = 32'h0;
    step();
    Data_MX = 32'h0000_00E1;
    step();
    check("fl_full", count, 2);
    flush = 1'b1; Data_MX = 32'h0000_00F0;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_count", count, 0);
    check("fl_out_valid", out_valid, 0);
    check("fl_op_mx", Op_MX, 0);
    check("fl_in_ready", in_ready, 1);
    in_valid = 1'b1; Data_MX = 32'h0000_00C0;
    step();
    check("fl1_count", count, 1);
    flush = 1'b1; Data_MX = 32'h0000_00C1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl1_dropped", count, 0);
    in_valid = 1'b1; Data_MX = 32'h0000_00D0;
    step();
    in_valid = 1'b0;
    check("fl_after_head", Op_MX, 32'h0000_00D0);
    check("fl_after_count", count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
